// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and default parameters for the parking gate arbiter
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OPENING = 2'd1,
      PASSING = 2'd2,
      CLOSING = 2'd3
   } state_t;

   typedef enum logic {
      LANE_ENTRY = 1'b0,
      LANE_EXIT  = 1'b1
   } lane_t;

   localparam int DEF_CAPACITY     = 10;
   localparam int DEF_CNT_W        = 8;
   localparam int DEF_MOVE_CYCLES  = 4;
   localparam int DEF_PASS_TIMEOUT = 64;
   localparam int DEF_TMR_W        = 8;

   function automatic lane_t other_lane(input lane_t lane);
      return (lane == LANE_ENTRY) ? LANE_EXIT : LANE_ENTRY;
   endfunction

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - loadable down-counter shared by the open, pass and close phases
module gate_timer
   import parking_pkg::*;
#(
   parameter int TMR_W = DEF_TMR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [TMR_W-1:0] value,
   input  logic             en,
   output logic             expired
);

   logic [TMR_W-1:0] remaining;

   // A phase loaded with N-1 stays active for N cycles, the last one with expired high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= value;
      end else if (en && (remaining != '0)) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign expired = (remaining == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - single-gate entry/exit arbiter with occupancy tracking
module parking_gate_arbiter
   import parking_pkg::*;
#(
   parameter int CAPACITY     = DEF_CAPACITY,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int MOVE_CYCLES  = DEF_MOVE_CYCLES,
   parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT,
   parameter int TMR_W        = DEF_TMR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             pass_sensor,
   output logic             entry_grant,
   output logic             exit_grant,
   output logic             gate_open,
   output logic             busy,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             entry_reject,
   output logic             timeout_err
);

   localparam logic [CNT_W-1:0] CAP_COUNT = CNT_W'(CAPACITY);
   localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(MOVE_CYCLES - 1);
   localparam logic [TMR_W-1:0] PASS_LOAD = TMR_W'(PASS_TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   lane_t            last_served;
   lane_t            lane_nxt;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_value;
   logic             tmr_en;
   logic             tmr_expired;

   logic             entry_ok;
   logic             exit_ok;

   logic             entry_grant_d;
   logic             exit_grant_d;
   logic             gate_open_d;
   logic             busy_d;
   logic             full_d;
   logic [CNT_W-1:0] count_d;
   logic             entry_reject_d;
   logic             timeout_err_d;

   assign entry_ok = entry_req && !full;
   assign exit_ok  = exit_req && (count != '0);
   assign tmr_en   = (state != IDLE);

   gate_timer #(
      .TMR_W (TMR_W)
   ) u_gate_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_load),
      .value   (tmr_value),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_served <= LANE_ENTRY;
      end else begin
         state       <= state_nxt;
         last_served <= lane_nxt;
      end
   end

   // last_served doubles as the lane owning the transaction in flight.
   always_comb begin
      state_nxt = state;
      lane_nxt  = last_served;
      tmr_load  = 1'b0;
      tmr_value = MOVE_LOAD;
      case (state)
         IDLE: begin
            if (entry_ok || exit_ok) begin
               state_nxt = OPENING;
               tmr_load  = 1'b1;
               tmr_value = MOVE_LOAD;
               if (entry_ok && exit_ok) begin
                  lane_nxt = other_lane(last_served);
               end else if (entry_ok) begin
                  lane_nxt = LANE_ENTRY;
               end else begin
                  lane_nxt = LANE_EXIT;
               end
            end
         end
         OPENING: begin
            if (tmr_expired) begin
               state_nxt = PASSING;
               tmr_load  = 1'b1;
               tmr_value = PASS_LOAD;
            end
         end
         PASSING: begin
            if (pass_sensor || tmr_expired) begin
               state_nxt = CLOSING;
               tmr_load  = 1'b1;
               tmr_value = MOVE_LOAD;
            end
         end
         CLOSING: begin
            if (tmr_expired) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      busy_d         = (state_nxt != IDLE);
      entry_grant_d  = busy_d && (lane_nxt == LANE_ENTRY);
      exit_grant_d   = busy_d && (lane_nxt == LANE_EXIT);
      gate_open_d    = (state_nxt == OPENING) || (state_nxt == PASSING);
      count_d        = count;
      if ((state == PASSING) && pass_sensor) begin
         if (last_served == LANE_ENTRY) begin
            count_d = count + CNT_W'(1);
         end else begin
            count_d = count - CNT_W'(1);
         end
      end
      full_d         = (count_d == CAP_COUNT);
      timeout_err_d  = (state == PASSING) && !pass_sensor && tmr_expired;
      entry_reject_d = (state == IDLE) && entry_req && full && !entry_grant_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_grant  <= 1'b0;
         exit_grant   <= 1'b0;
         gate_open    <= 1'b0;
         busy         <= 1'b0;
         full         <= 1'b0;
         count        <= '0;
         entry_reject <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         entry_grant  <= entry_grant_d;
         exit_grant   <= exit_grant_d;
         gate_open    <= gate_open_d;
         busy         <= busy_d;
         full         <= full_d;
         count        <= count_d;
         entry_reject <= entry_reject_d;
         timeout_err  <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed self-checking bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

   localparam int MOVE = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic       pass_sensor = 1'b0;
   logic       entry_grant;
   logic       exit_grant;
   logic       gate_open;
   logic       busy;
   logic       full;
   logic [7:0] count;
   logic       entry_reject;
   logic       timeout_err;

   int vectors = 0;
   int miscompares = 0;

   parking_gate_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .entry_req    (entry_req),
      .exit_req     (exit_req),
      .pass_sensor  (pass_sensor),
      .entry_grant  (entry_grant),
      .exit_grant   (exit_grant),
      .gate_open    (gate_open),
      .busy         (busy),
      .full         (full),
      .count        (count),
      .entry_reject (entry_reject),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Starts in IDLE, leaves requests as given, ends on the first IDLE cycle afterwards.
   task automatic txn(input logic e, input logic x, input int pass_idx,
                      output logic ge, output logic gx);
      entry_req = e;
      exit_req  = x;
      tick();
      ge = entry_grant;
      gx = exit_grant;
      repeat (MOVE) tick();
      repeat (pass_idx) tick();
      pass_sensor = 1'b1;
      tick();
      pass_sensor = 1'b0;
      repeat (MOVE) tick();
   endtask

   initial begin
      logic ge;
      logic gx;

      #2 reset = 1'b1;
      #1;
      chk("rst_async_busy", busy, 1'b0);
      chk("rst_async_gate", gate_open, 1'b0);
      chk("rst_async_count", count, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      chk("rst_full", full, 1'b0);
      chk("rst_grants", {entry_grant, exit_grant}, 2'b00);
      chk("rst_reject", entry_reject, 1'b0);
      chk("rst_timeout", timeout_err, 1'b0);

      // single entry with pass in the third PASSING cycle
      entry_req = 1'b1;
      tick();
      chk("t1_c1_entry_grant", entry_grant, 1'b1);
      chk("t1_c1_exit_grant", exit_grant, 1'b0);
      chk("t1_c1_gate_open", gate_open, 1'b1);
      chk("t1_c1_busy", busy, 1'b1);
      entry_req = 1'b0;
      repeat (3) tick();
      chk("t1_c4_gate_open", gate_open, 1'b1);
      repeat (3) tick();
      chk("t1_c7_count", count, 8'd0);
      pass_sensor = 1'b1;
      tick();
      pass_sensor = 1'b0;
      chk("t1_c8_count", count, 8'd1);
      chk("t1_c8_gate_open", gate_open, 1'b0);
      chk("t1_c8_busy", busy, 1'b1);
      chk("t1_c8_entry_grant", entry_grant, 1'b1);
      repeat (3) tick();
      chk("t1_c11_busy", busy, 1'b1);
      tick();
      chk("t1_c12_busy", busy, 1'b0);
      chk("t1_c12_entry_grant", entry_grant, 1'b0);

      // fill to capacity
      for (int i = 0; i < 9; i++) begin
         txn(1'b1, 1'b0, 0, ge, gx);
         chk("fill_grant", ge, 1'b1);
         chk("fill_count", count, 8'(i + 2));
         chk("fill_full", full, (i == 8) ? 1'b1 : 1'b0);
      end
      tick();
      chk("full_reject_1", entry_reject, 1'b1);
      chk("full_no_grant", entry_grant, 1'b0);
      chk("full_not_busy", busy, 1'b0);
      tick();
      chk("full_reject_2", entry_reject, 1'b1);
      chk("full_count", count, 8'd10);
      entry_req = 1'b0;
      tick();
      chk("full_reject_clear", entry_reject, 1'b0);

      // alternating priority on ties
      do_reset();
      for (int i = 0; i < 5; i++) txn(1'b1, 1'b0, 0, ge, gx);
      entry_req = 1'b0;
      chk("tie_start_count", count, 8'd5);
      txn(1'b1, 1'b1, 1, ge, gx);
      chk("tie1_grants", {ge, gx}, 2'b01);
      chk("tie1_count", count, 8'd4);
      txn(1'b1, 1'b1, 0, ge, gx);
      chk("tie2_grants", {ge, gx}, 2'b10);
      chk("tie2_count", count, 8'd5);
      txn(1'b1, 1'b1, 2, ge, gx);
      chk("tie3_grants", {ge, gx}, 2'b01);
      chk("tie3_count", count, 8'd4);
      entry_req = 1'b0;
      exit_req  = 1'b0;

      // pass timeout
      entry_req = 1'b1;
      tick();
      chk("to_grant", entry_grant, 1'b1);
      entry_req = 1'b0;
      repeat (MOVE + 63) tick();
      chk("to_c68_err", timeout_err, 1'b0);
      chk("to_c68_gate", gate_open, 1'b1);
      tick();
      chk("to_c69_err", timeout_err, 1'b1);
      chk("to_c69_gate", gate_open, 1'b0);
      chk("to_c69_count", count, 8'd4);
      tick();
      chk("to_c70_err", timeout_err, 1'b0);
      repeat (3) tick();
      chk("to_c73_busy", busy, 1'b0);
      chk("to_c73_grant", entry_grant, 1'b0);

      // exit request with empty park
      do_reset();
      exit_req = 1'b1;
      repeat (3) tick();
      chk("empty_exit_busy", busy, 1'b0);
      chk("empty_exit_grant", exit_grant, 1'b0);
      chk("empty_exit_count", count, 8'd0);
      exit_req = 1'b0;

      // reset in the middle of an exit pass
      for (int i = 0; i < 3; i++) txn(1'b1, 1'b0, 0, ge, gx);
      entry_req = 1'b0;
      chk("mid_count3", count, 8'd3);
      exit_req = 1'b1;
      tick();
      chk("mid_exit_grant", exit_grant, 1'b1);
      exit_req = 1'b0;
      repeat (5) tick();
      chk("mid_gate_open", gate_open, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_gate", gate_open, 1'b0);
      chk("mid_rst_grants", {entry_grant, exit_grant}, 2'b00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_count", count, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      txn(1'b1, 1'b0, 0, ge, gx);
      chk("post_rst_entry", {ge, gx}, 2'b10);
      txn(1'b1, 1'b1, 0, ge, gx);
      chk("post_rst_tie", {ge, gx}, 2'b01);
      chk("post_rst_count", count, 8'd0);
      entry_req = 1'b0;
      exit_req  = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
